// File: rtl/tbird_pkg.sv
// tbird_pkg: lamp pattern constants, mode encoding and state/pattern enums
// shared by the Thunderbird lamp monitor and its pattern decoder.
package tbird_pkg;

    localparam logic [5:0] LAMP_OFF = 6'b000000;
    localparam logic [5:0] LAMP_L1  = 6'b001000;
    localparam logic [5:0] LAMP_L2  = 6'b011000;
    localparam logic [5:0] LAMP_L3  = 6'b111000;
    localparam logic [5:0] LAMP_R1  = 6'b000100;
    localparam logic [5:0] LAMP_R2  = 6'b000110;
    localparam logic [5:0] LAMP_R3  = 6'b000111;
    localparam logic [5:0] LAMP_HAZ = 6'b111111;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_HAZ   = 2'b11;

    typedef enum logic [3:0] {
        P_OFF, P_L1, P_L2, P_L3, P_R1, P_R2, P_R3, P_HAZ, P_ILL
    } pat_t;

    typedef enum logic [3:0] {
        S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_HAZ, S_ERR
    } state_t;

    function automatic logic [1:0] state_mode(state_t s);
        return (s inside {S_L1, S_L2, S_L3}) ? MODE_LEFT :
               (s inside {S_R1, S_R2, S_R3}) ? MODE_RIGHT :
               (s == S_HAZ)                  ? MODE_HAZ : MODE_OFF;
    endfunction

endpackage

// File: rtl/tbird_lamp_decode.sv
// tbird_lamp_decode: classifies a raw lamp vector into one of the legal
// patterns, or P_ILL for anything else.
module tbird_lamp_decode
    import tbird_pkg::*;
(
    input  logic [5:0] lamps,
    output pat_t       pat
);

    always_comb begin
        pat = (lamps == LAMP_OFF) ? P_OFF :
              (lamps == LAMP_L1)  ? P_L1  :
              (lamps == LAMP_L2)  ? P_L2  :
              (lamps == LAMP_L3)  ? P_L3  :
              (lamps == LAMP_R1)  ? P_R1  :
              (lamps == LAMP_R2)  ? P_R2  :
              (lamps == LAMP_R3)  ? P_R3  :
              (lamps == LAMP_HAZ) ? P_HAZ : P_ILL;
    end

endmodule

// File: rtl/tbird_lamp_monitor.sv
// tbird_lamp_monitor: checks stepped lamp patterns against the legal
// left/right/hazard sequences, counting completions and flagging errors.
module tbird_lamp_monitor
    import tbird_pkg::*;
#(
    parameter int HOLD_MAX = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic       step,
    input  logic [5:0] lamps,
    output logic [1:0] mode,
    output logic       cycle_done,
    output logic [7:0] cycle_count,
    output logic       error
);

    localparam int HW = $clog2(HOLD_MAX + 2);

    pat_t          pat;
    state_t        state, nxt, fin;
    logic [HW-1:0] hold;
    logic          held, over, done;

    tbird_lamp_decode u_decode (.lamps(lamps), .pat(pat));

    always_comb begin
        nxt = S_ERR;
        case (state)
            S_IDLE:  nxt = (pat == P_OFF) ? S_IDLE : (pat == P_L1) ? S_L1 :
                           (pat == P_R1) ? S_R1 : (pat == P_HAZ) ? S_HAZ : S_ERR;
            S_L1:    nxt = (pat == P_L1) ? S_L1 : (pat == P_L2) ? S_L2 : (pat == P_HAZ) ? S_HAZ : S_ERR;
            S_L2:    nxt = (pat == P_L2) ? S_L2 : (pat == P_L3) ? S_L3 : (pat == P_HAZ) ? S_HAZ : S_ERR;
            S_R1:    nxt = (pat == P_R1) ? S_R1 : (pat == P_R2) ? S_R2 : (pat == P_HAZ) ? S_HAZ : S_ERR;
            S_R2:    nxt = (pat == P_R2) ? S_R2 : (pat == P_R3) ? S_R3 : (pat == P_HAZ) ? S_HAZ : S_ERR;
            S_L3:    nxt = (pat == P_L3) ? S_L3 : (pat == P_OFF) ? S_IDLE : S_ERR;
            S_R3:    nxt = (pat == P_R3) ? S_R3 : (pat == P_OFF) ? S_IDLE : S_ERR;
            S_HAZ:   nxt = (pat == P_HAZ) ? S_HAZ : (pat == P_OFF) ? S_IDLE : S_ERR;
            default: nxt = (pat == P_OFF) ? S_IDLE : S_ERR;
        endcase
        // hold counts steps already spent on the current pattern
        held = (nxt == state) && !(state inside {S_IDLE, S_ERR});
        over = held && (hold >= HW'(HOLD_MAX));
        fin  = over ? S_ERR : nxt;
        done = (fin == S_IDLE) && (state inside {S_L3, S_R3, S_HAZ});
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= S_IDLE;
            hold        <= '0;
            mode        <= MODE_OFF;
            cycle_done  <= 1'b0;
            cycle_count <= 8'd0;
            error       <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            if (en && step) begin
                state       <= fin;
                hold        <= (fin inside {S_IDLE, S_ERR}) ? '0 : held ? hold + 1'b1 : HW'(1);
                mode        <= state_mode(fin);
                cycle_done  <= done;
                cycle_count <= cycle_count + {7'd0, done && (cycle_count != 8'hff)};
                error       <= error | (fin == S_ERR);
            end
        end
    end

endmodule

// File: tb/tb_tbird_lamp_monitor.sv
// tb_tbird_lamp_monitor: directed stimulus with a rule-level model compared
// every cycle, plus literal expectations for the documented scenarios.
module tb_tbird_lamp_monitor;

    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       clr, en, step;
    logic [5:0] lamps;
    logic [1:0] mode;
    logic       cycle_done, error;
    logic [7:0] cycle_count;

    int checks = 0;
    int passes = 0;
    bit cmp_on = 1'b0;

    typedef struct {
        logic [1:0] dir;
        int         lvl;
        int         run;
        logic       in_err;
        logic       error;
        logic       done;
        int         count;
    } model_t;

    model_t m;

    tbird_lamp_monitor #(.HOLD_MAX(HOLD)) dut (
        .clk(clk), .clr(clr), .en(en), .step(step), .lamps(lamps),
        .mode(mode), .cycle_done(cycle_done), .cycle_count(cycle_count), .error(error)
    );

    always #5 clk = ~clk;

    // kind: 0 off, 1 left, 2 right, 3 hazard, 4 illegal; lvl = lit lamps on the active side
    function automatic model_t model_step(model_t c, logic [5:0] l);
        model_t n;
        int kind, lvl;
        bit bad;
        n = c;
        n.done = 1'b0;
        bad = 1'b0;
        if (l == 6'd0) kind = 0;
        else if (l == 6'h3f) kind = 3;
        else if (l[2:0] == 3'd0 && l[5:3] inside {3'b001, 3'b011, 3'b111}) kind = 1;
        else if (l[5:3] == 3'd0 && l[2:0] inside {3'b100, 3'b110, 3'b111}) kind = 2;
        else kind = 4;
        lvl = (kind == 1) ? $countones(l[5:3]) : (kind == 2) ? $countones(l[2:0]) : 0;
        if (c.in_err) begin
            if (kind == 0) n.in_err = 1'b0;
            return n;
        end
        if (c.dir == 2'd0) begin
            if (kind == 3 || (kind inside {1, 2} && lvl == 1)) begin
                n.dir = 2'(kind); n.lvl = lvl; n.run = 1;
            end else if (kind != 0) bad = 1'b1;
        end else if (kind == int'(c.dir) && lvl == c.lvl) begin
            n.run = c.run + 1;
            bad = n.run > HOLD;
        end else if (kind == 0) begin
            if (c.dir == 2'd3 || c.lvl == 3) begin
                n.done = 1'b1; n.dir = 2'd0; n.lvl = 0; n.run = 0;
                n.count = (c.count == 255) ? 255 : c.count + 1;
            end else bad = 1'b1;
        end else if (kind == 3 && c.dir != 2'd3 && c.lvl < 3) begin
            n.dir = 2'd3; n.lvl = 0; n.run = 1;
        end else if (kind == int'(c.dir) && c.dir != 2'd3 && lvl == c.lvl + 1) begin
            n.lvl = lvl; n.run = 1;
        end else bad = 1'b1;
        if (bad) begin
            n.in_err = 1'b1; n.error = 1'b1; n.dir = 2'd0; n.lvl = 0; n.run = 0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge clr) begin
        if (!clr) m <= '{2'd0, 0, 0, 1'b0, 1'b0, 1'b0, 0};
        else if (en && step) m <= model_step(m, lamps);
        else m.done <= 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_mode", int'(mode), int'(m.dir));
            chk("model_done", int'(cycle_done), int'(m.done));
            chk("model_count", int'(cycle_count), m.count);
            chk("model_error", int'(error), int'(m.error));
        end
    end

    // caller sits just after a rising edge; returns just after the step edge
    task automatic do_step(input logic [5:0] l, input logic e = 1'b1);
        lamps = l; step = 1'b1; en = e;
        @(posedge clk); #1;
        step = 1'b0; en = 1'b1; lamps = 6'b101101;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reset_pulse();
        clr = 1'b0; #2; clr = 1'b1;
        idle(1);
    endtask

    initial begin
        clr = 1'b0; en = 1'b1; step = 1'b0; lamps = 6'd0;
        idle(2);
        chk("rst_mode", int'(mode), 0);
        chk("rst_count", int'(cycle_count), 0);
        chk("rst_error", int'(error), 0);
        clr = 1'b1;
        cmp_on = 1'b1;
        idle(1);

        // left cycle
        do_step(6'b001000); chk("left_mode", int'(mode), 1);
        do_step(6'b001000); do_step(6'b011000); do_step(6'b011000);
        do_step(6'b111000); chk("left_done_early", int'(cycle_done), 0);
        do_step(6'b000000);
        chk("left_done", int'(cycle_done), 1);
        chk("left_count", int'(cycle_count), 1);
        chk("left_error", int'(error), 0);
        idle(1); chk("left_pulse", int'(cycle_done), 0);

        // hazard override of a right sequence
        do_step(6'b000100); chk("haz_m1", int'(mode), 2);
        do_step(6'b000100); chk("haz_m2", int'(mode), 2);
        do_step(6'b111111); chk("haz_m3", int'(mode), 3);
        do_step(6'b000000); chk("haz_m4", int'(mode), 0);
        chk("haz_done", int'(cycle_done), 1);
        chk("haz_count", int'(cycle_count), 2);
        idle(2);

        // hold violation on L2
        do_step(6'b001000); do_step(6'b011000); do_step(6'b011000);
        chk("hold_ok", int'(error), 0);
        do_step(6'b011000);
        chk("hold_err", int'(error), 1);
        chk("hold_mode", int'(mode), 0);
        do_step(6'b000000);
        chk("hold_nodone", int'(cycle_done), 0);
        chk("hold_sticky", int'(error), 1);
        idle(1);

        // illegal pattern from idle, then a legal right cycle
        reset_pulse();
        do_step(6'b101000); chk("ill_err", int'(error), 1);
        do_step(6'b000111); chk("ill_stay", int'(mode), 0);
        do_step(6'b000000);
        do_step(6'b000100); do_step(6'b000110); do_step(6'b000111); do_step(6'b000000);
        chk("ill_done", int'(cycle_done), 1);
        chk("ill_count", int'(cycle_count), 1);
        chk("ill_sticky", int'(error), 1);

        // reset mid-sequence in L2
        do_step(6'b001000); do_step(6'b011000);
        chk("mid_mode", int'(mode), 1);
        clr = 1'b0; #1;
        chk("mid_rst_mode", int'(mode), 0);
        chk("mid_rst_count", int'(cycle_count), 0);
        chk("mid_rst_error", int'(error), 0);
        chk("mid_rst_done", int'(cycle_done), 0);
        #1; clr = 1'b1;
        idle(1);
        do_step(6'b000100); chk("mid_r1", int'(mode), 2);
        do_step(6'b000000); chk("mid_err", int'(error), 1);
        reset_pulse();

        // saturation: 256 hazard cycles
        for (int i = 0; i < 256; i++) begin
            do_step(6'b111111); do_step(6'b000000);
        end
        chk("sat_count", int'(cycle_count), 255);
        chk("sat_done", int'(cycle_done), 1);
        idle(1);
        do_step(6'b111111, 1'b0); do_step(6'b101010, 1'b0);
        chk("en0_mode", int'(mode), 0);
        chk("en0_error", int'(error), 0);
        chk("en0_count", int'(cycle_count), 255);
        do_step(6'b111111); do_step(6'b000000);
        chk("sat_pulse", int'(cycle_done), 1);
        chk("sat_hold", int'(cycle_count), 255);

        // hazard hold limit, then L3 followed by hazard
        do_step(6'b111111); do_step(6'b111111); do_step(6'b111111);
        chk("hazhold_err", int'(error), 1);
        reset_pulse();
        do_step(6'b001000); do_step(6'b011000); do_step(6'b111000); do_step(6'b111111);
        chk("l3haz_err", int'(error), 1);
        do_step(6'b000000); idle(2);

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
